// File: rtl/writeback_if.sv
// Register-file port driven by the writeback stage: one write port plus the two
// decode read ports, whose data returns into the writeback stage for forwarding.
interface writeback_if #(
    parameter int XLEN = 32
);
    // write_enable is a strobe with no ready: the register file commits
    // write_data to write_reg on every rising edge where write_enable is high.
    logic            write_enable;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic [4:0]      read_reg1;
    logic [4:0]      read_reg2;
    logic [XLEN-1:0] rf_read_data1;
    logic [XLEN-1:0] rf_read_data2;

    modport master (
        output write_enable,
        output write_reg,
        output write_data,
        output read_reg1,
        output read_reg2,
        input  rf_read_data1,
        input  rf_read_data2
    );

    modport slave (
        input  write_enable,
        input  write_reg,
        input  write_data,
        input  read_reg1,
        input  read_reg2,
        output rf_read_data1,
        output rf_read_data2
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: WB pipeline register, load extraction, register-file write
// port, write-through forwarding onto the decode read ports, retire counter.
module writeback_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] retired_count,
    writeback_if.master     rf
);

    logic            wb_valid;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] retired_q;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] next_result;
    logic            write_enable;
    logic            retire;

    // Byte lane picked by the low address bits; halfword by bit 1 only.
    always_comb begin
        ld_byte = mem_load_data[7:0];
        case (mem_alu_result[1:0])
            2'd0: ld_byte = mem_load_data[7:0];
            2'd1: ld_byte = mem_load_data[15:8];
            2'd2: ld_byte = mem_load_data[23:16];
            2'd3: ld_byte = mem_load_data[31:24];
            default: ld_byte = mem_load_data[7:0];
        endcase
        ld_half = mem_alu_result[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    end

    always_comb begin
        load_value = mem_load_data;
        case (mem_funct3)
            3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_value = {24'd0, ld_byte};
            3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_value = {16'd0, ld_half};
            default: load_value = mem_load_data;
        endcase
    end

    always_comb begin
        next_result = mem_alu_result;
        case (mem_wb_sel)
            2'b01:   next_result = load_value;
            2'b10:   next_result = mem_pc_plus4;
            default: next_result = mem_alu_result;
        endcase
    end

    // Flush only drops the valid bit; the payload fields simply hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_result    <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= mem_valid;
            wb_reg_write <= mem_reg_write;
            wb_rd        <= mem_rd;
            wb_result    <= next_result;
        end
    end

    assign retire = wb_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired_count = retired_q;

    // Stall does not gate the strobe: a held write just rewrites the same value.
    assign write_enable    = wb_valid & wb_reg_write & (wb_rd != 5'd0);
    assign rf.write_enable = write_enable;
    assign rf.write_reg    = wb_rd;
    assign rf.write_data   = wb_result;
    assign rf.read_reg1    = rs1_addr;
    assign rf.read_reg2    = rs2_addr;

    // Forward the in-flight write during the cycle before the file commits it.
    always_comb begin
        rs1_data = rf.rf_read_data1;
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (write_enable && (wb_rd == rs1_addr)) begin
            rs1_data = wb_result;
        end
    end

    always_comb begin
        rs2_data = rf.rf_read_data2;
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (write_enable && (wb_rd == rs2_addr)) begin
            rs2_data = wb_result;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected register-file writes are queued when
// an instruction is driven and popped when the write strobe appears.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc_plus4;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] retired_count;

  writeback_if #(.XLEN(32)) rf_bus ();

  writeback_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .retired_count  (retired_count),
    .rf             (rf_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  logic        m_valid = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present one memory-stage instruction; queue its write if it will land
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc, input logic [31:0] exp_data);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_pc_plus4   = pc;
    if (reset && !stall && !flush && v && rw && (rd != 5'd0))
      exp_q.push_back({rd, exp_data});
  endtask

  // one clock: advance the retire model, then check the counter after the edge
  task automatic step();
    logic ret;
    ret = reset && m_valid && !stall && !flush;
    if (reset) begin
      if (flush) m_valid = 1'b0;
      else if (!stall) m_valid = mem_valid;
    end
    @(posedge clk);
    #1;
    if (ret) exp_cnt = exp_cnt + 32'd1;
    chk("retired_count", retired_count, exp_cnt);
  endtask

  // scoreboard: pop one expected write per capture edge, or require no strobe
  task automatic check_write();
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      chk("we_idle", {31'd0, rf_bus.write_enable}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("we", {31'd0, rf_bus.write_enable}, 32'd1);
      chk("write_reg", {27'd0, rf_bus.write_reg}, {27'd0, e[36:32]});
      chk("write_data", rf_bus.write_data, e[31:0]);
    end
  endtask

  logic [1:0]  t_sel[10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
  logic [2:0]  t_f3[10]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101, 3'b000, 3'b000, 3'b111};
  logic [31:0] t_alu[10] = '{32'h1003, 32'h2003, 32'h3002, 32'h3000, 32'h3001,
                             32'h0001, 32'h0003, 32'h0055, 32'hCAFEF00D, 32'h0002};
  logic [31:0] t_exp[10] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F4, 32'h00007F12, 32'h80F47F12,
                             32'h0000007F, 32'h000080F4, 32'h00400104, 32'hCAFEF00D, 32'h80F47F12};

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd4;
    rf_bus.rf_read_data1 = 32'd0;
    rf_bus.rf_read_data2 = 32'h1234;
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b010, 32'h11112222, 32'h0, 32'h0, 32'h0);

    // reset held 100 ns with an active memory stage
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_we", {31'd0, rf_bus.write_enable}, 32'd0);
      chk("rst_wdata", rf_bus.write_data, 32'd0);
      chk("rst_rs1_x0", rs1_data, 32'd0);
      chk("rst_rs2_pass", rs2_data, 32'h1234);
    end

    mem_valid = 1'b0;
    reset = 1'b1;
    step();
    check_write();

    // ALU write then forwarding on both ports
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hA5A5A5A5);
    step();
    check_write();
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    rf_bus.rf_read_data1 = 32'd0;
    rf_bus.rf_read_data2 = 32'h11;
    #1;
    chk("fwd_rs1", rs1_data, 32'hA5A5A5A5);
    chk("fwd_rs2", rs2_data, 32'hA5A5A5A5);
    chk("read_reg1", {27'd0, rf_bus.read_reg1}, 32'd5);

    // rd = x0 never writes but still retires
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b010, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    step();
    check_write();
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    rf_bus.rf_read_data1 = 32'h55;
    rf_bus.rf_read_data2 = 32'h99;
    #1;
    chk("x0_rs2", rs2_data, 32'd0);
    chk("nofwd_rs1", rs1_data, 32'h55);

    // load extraction, link and ALU-alias selects
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), t_sel[i], t_f3[i], t_alu[i], 32'h80F47F12,
            32'h00400104, t_exp[i]);
      step();
      check_write();
    end

    // flush and stall together: flush wins, nothing retires
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b010, 32'h33333333, 32'h0, 32'h0, 32'h33333333);
    step();
    chk("flush_wb_valid", {31'd0, dut.wb_valid}, 32'd0);
    chk("flush_we", {31'd0, rf_bus.write_enable}, 32'd0);

    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b010, 32'h33333333, 32'h0, 32'h0, 32'h33333333);
    step();
    check_write();

    // stall alone holds the write for three cycles
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b010, 32'h99999999, 32'h0, 32'h0, 32'h99999999);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_we", {31'd0, rf_bus.write_enable}, 32'd1);
      chk("stall_reg", {27'd0, rf_bus.write_reg}, 32'd3);
      chk("stall_data", rf_bus.write_data, 32'h33333333);
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check_write();

    // counter wrap from all-ones
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    exp_cnt = 32'hFFFFFFFF;
    #1;
    chk("preload", retired_count, exp_cnt);
    drive(1'b1, 1'b0, 5'd4, 2'b00, 3'b010, 32'h4, 32'h0, 32'h0, 32'h4);
    step();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("wrap_zero", retired_count, 32'd0);

    // reset asserted mid-write kills the strobe at once
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b010, 32'h66666666, 32'h0, 32'h0, 32'h66666666);
    step();
    check_write();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_we", {31'd0, rf_bus.write_enable}, 32'd0);
    chk("midrst_reg", {27'd0, rf_bus.write_reg}, 32'd0);
    chk("midrst_data", rf_bus.write_data, 32'd0);
    chk("midrst_cnt", retired_count, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
